// File: rtl/matrix_cursor_display.sv
// -----------------------------------------------------------------------------
// matrix_cursor_display
//
// Cursor register and two-digit seven-segment driver for the Buscaminas board.
// The cursor (fila, columna) moves one step per direction pulse with
// wrap-around at the board edges, or is loaded directly (saturated to the
// board size). Each coordinate is shown as one active-low hex digit. While
// parpadeo_en is set, both digits blink with a half-period of BLINK_DIV
// cycles. Any accepted movement restarts the blink so the cursor is visible
// straight away.
//
// Parameters
//   ROWS       number of board rows            (2..16)
//   COLS       number of board columns         (2..16)
//   BLINK_DIV  clock cycles per blink half-period (>= 2)
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   arriba         single-cycle pulse, row - 1 (wraps to ROWS-1)
//   abajo          single-cycle pulse, row + 1 (wraps to 0)
//   izquierda      single-cycle pulse, column - 1 (wraps to COLS-1)
//   derecha        single-cycle pulse, column + 1 (wraps to 0)
//   cargar         load fila_in / columna_in (overrides direction pulses)
//   fila_in        row to load, saturated to ROWS-1
//   columna_in     column to load, saturated to COLS-1
//   parpadeo_en    enable blinking of both digits
//   fila           current cursor row (registered)
//   columna        current cursor column (registered)
//   salidaFila     row digit segments, active-low, bit6=g .. bit0=a
//   salidaColumna  column digit segments, same encoding
// -----------------------------------------------------------------------------
module matrix_cursor_display #(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arriba,
  input  logic                      abajo,
  input  logic                      izquierda,
  input  logic                      derecha,
  input  logic                      cargar,
  input  logic [3:0]                fila_in,
  input  logic [3:0]                columna_in,
  input  logic                      parpadeo_en,
  output logic [$clog2(ROWS)-1:0]   fila,
  output logic [$clog2(COLS)-1:0]   columna,
  output logic [6:0]                salidaFila,
  output logic [6:0]                salidaColumna
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CNT_W = $clog2(BLINK_DIV);

  localparam logic [RW-1:0]    ROW_LAST    = RW'(ROWS - 1);
  localparam logic [CW-1:0]    COL_LAST    = CW'(COLS - 1);
  localparam logic [RW-1:0]    ROW_ONE     = RW'(1);
  localparam logic [CW-1:0]    COL_ONE     = CW'(1);
  // Load limits expressed at the width of the 4-bit load inputs.
  localparam logic [3:0]       ROW_LAST_IN = 4'(ROWS - 1);
  localparam logic [3:0]       COL_LAST_IN = 4'(COLS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low hex decode, bit6=g .. bit0=a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    unique case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // Next cursor position
  // ---------------------------------------------------------------------------
  logic [RW-1:0] row_next;
  logic [CW-1:0] col_next;
  logic          move_event;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so a
    // path that does not assign it cannot infer a latch.
    row_next = fila;
    col_next = columna;

    if (cargar) begin
      row_next = (fila_in > ROW_LAST_IN) ? ROW_LAST : fila_in[RW-1:0];
      col_next = (columna_in > COL_LAST_IN) ? COL_LAST : columna_in[CW-1:0];
    end else begin
      // Opposing pulses on the same axis cancel and leave it unchanged.
      if (arriba && !abajo) begin
        row_next = (fila == '0) ? ROW_LAST : fila - ROW_ONE;
      end else if (abajo && !arriba) begin
        row_next = (fila == ROW_LAST) ? '0 : fila + ROW_ONE;
      end

      if (izquierda && !derecha) begin
        col_next = (columna == '0) ? COL_LAST : columna - COL_ONE;
      end else if (derecha && !izquierda) begin
        col_next = (columna == COL_LAST) ? '0 : columna + COL_ONE;
      end
    end
  end

  // A load always counts as movement; a direction pulse counts only when it
  // actually changes a coordinate (cancelled pulses do not restart the blink).
  assign move_event = cargar || (row_next != fila) || (col_next != columna);

  // ---------------------------------------------------------------------------
  // Cursor registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    if (rst) begin
      fila    <= '0;
      columna <= '0;
    end else begin
      fila    <= row_next;
      columna <= col_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timebase
  // The counter free-runs 0..BLINK_DIV-1 and the phase flips on each wrap.
  // Movement restarts both so the new position is shown for a full half-period.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (move_event) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Segment output registers
  // Decoded from the registered cursor and phase, so the digits trail a move
  // or a phase change by exactly one edge and never glitch.
  // ---------------------------------------------------------------------------
  logic blank;
  assign blank = parpadeo_en && blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      salidaFila    <= SEG_ZERO;
      salidaColumna <= SEG_ZERO;
    end else if (blank) begin
      salidaFila    <= SEG_BLANK;
      salidaColumna <= SEG_BLANK;
    end else begin
      salidaFila    <= hex_to_seg(4'(fila));
      salidaColumna <= hex_to_seg(4'(columna));
    end
  end

endmodule

// File: tb/tb_matrix_cursor_display.sv
// -----------------------------------------------------------------------------
// tb_matrix_cursor_display
//
// Two instances share one stimulus stream: an 8x8 board blinking every 4
// cycles and a 16x10 board blinking every 5 cycles. A behavioural model keeps
// each cursor as plain integers (modulo arithmetic for wrap, min() for load)
// and the blink as the number of cycles since the last movement or reset.
// Every falling edge compares all outputs of both instances with the model;
// directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_matrix_cursor_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       arriba, abajo, izquierda, derecha, cargar, parpadeo_en;
  logic [3:0] fila_in, columna_in;

  logic [2:0] fila0, columna0;
  logic [6:0] seg_fila0, seg_col0;
  logic [3:0] fila1, columna1;
  logic [6:0] seg_fila1, seg_col1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_cursor_display #(.ROWS(8), .COLS(8), .BLINK_DIV(4)) dut0 (
    .clk(clk), .rst(rst),
    .arriba(arriba), .abajo(abajo), .izquierda(izquierda), .derecha(derecha),
    .cargar(cargar), .fila_in(fila_in), .columna_in(columna_in),
    .parpadeo_en(parpadeo_en),
    .fila(fila0), .columna(columna0),
    .salidaFila(seg_fila0), .salidaColumna(seg_col0)
  );

  matrix_cursor_display #(.ROWS(16), .COLS(10), .BLINK_DIV(5)) dut1 (
    .clk(clk), .rst(rst),
    .arriba(arriba), .abajo(abajo), .izquierda(izquierda), .derecha(derecha),
    .cargar(cargar), .fila_in(fila_in), .columna_in(columna_in),
    .parpadeo_en(parpadeo_en),
    .fila(fila1), .columna(columna1),
    .salidaFila(seg_fila1), .salidaColumna(seg_col1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  function automatic int rows_of(input int i);
    return (i == 0) ? 8 : 16;
  endfunction

  function automatic int cols_of(input int i);
    return (i == 0) ? 8 : 10;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // New coordinate: load saturates, otherwise step by (inc - dec) modulo n.
  function automatic int move_to(input int pos, input int n, input logic dec,
                                 input logic inc, input logic ld,
                                 input logic [3:0] ld_val);
    if (ld) return (int'(ld_val) > n - 1) ? n - 1 : int'(ld_val);
    return (pos + int'(inc) - int'(dec) + n) % n;
  endfunction

  int         m_row [2];
  int         m_col [2];
  int         m_age [2];  // cycles since the last movement or reset
  logic [6:0] m_sf  [2];
  logic [6:0] m_sc  [2];

  function automatic int next_row(input int i);
    return move_to(m_row[i], rows_of(i), arriba, abajo, cargar, fila_in);
  endfunction

  function automatic int next_col(input int i);
    return move_to(m_col[i], cols_of(i), izquierda, derecha, cargar, columna_in);
  endfunction

  function automatic logic moved(input int i);
    return cargar || (next_row(i) != m_row[i]) || (next_col(i) != m_col[i]);
  endfunction

  // Blanked during odd half-periods of the age count.
  function automatic logic hidden(input int i);
    return parpadeo_en && (((m_age[i] / div_of(i)) % 2) == 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_row[i] <= 0;
        m_col[i] <= 0;
        m_age[i] <= 0;
        m_sf[i]  <= 7'b1000000;
        m_sc[i]  <= 7'b1000000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sf[i]  <= hidden(i) ? 7'b1111111 : seg_of(m_row[i]);
        m_sc[i]  <= hidden(i) ? 7'b1111111 : seg_of(m_col[i]);
        m_row[i] <= next_row(i);
        m_col[i] <= next_col(i);
        m_age[i] <= moved(i) ? 0 : m_age[i] + 1;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("m_fila0",    int'(fila0),     m_row[0]);
    check("m_columna0", int'(columna0),  m_col[0]);
    check("m_segfila0", int'(seg_fila0), int'(m_sf[0]));
    check("m_segcol0",  int'(seg_col0),  int'(m_sc[0]));
    check("m_fila1",    int'(fila1),     m_row[1]);
    check("m_columna1", int'(columna1),  m_col[1]);
    check("m_segfila1", int'(seg_fila1), int'(m_sf[1]));
    check("m_segcol1",  int'(seg_col1),  int'(m_sc[1]));
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic c, input int fi, input int ci, input logic u,
                       input logic d, input logic l, input logic r);
    @(negedge clk);
    cargar     = c;
    fila_in    = 4'(fi);
    columna_in = 4'(ci);
    arriba     = u;
    abajo      = d;
    izquierda  = l;
    derecha    = r;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    parpadeo_en = 1'b0;
    cargar = 1'b0; arriba = 1'b0; abajo = 1'b0; izquierda = 1'b0; derecha = 1'b0;
    fila_in = '0; columna_in = '0;

    // Reset values
    tick();
    check("rst_fila",    int'(fila0),     0);
    check("rst_columna", int'(columna0),  0);
    check("rst_segfila", int'(seg_fila0), 7'b1000000);
    check("rst_segcol",  int'(seg_col0),  7'b1000000);
    @(negedge clk);
    rst = 1'b0;

    // Load (2,5); digits two edges after the load
    drive(1'b1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("load_fila",    int'(fila0),    2);
    check("load_columna", int'(columna0), 5);
    idle(); tick();
    check("load_segfila", int'(seg_fila0), 7'b0100100);
    check("load_segcol",  int'(seg_col0),  7'b0010010);

    // Asynchronous reset with no clock edge, cursor at row 3
    drive(1'b1, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("pre_rst_fila", int'(fila0), 3);
    #2 rst = 1'b1;
    #1;
    check("async_fila",    int'(fila0),     0);
    check("async_columna", int'(columna0),  0);
    check("async_segfila", int'(seg_fila0), 7'b1000000);
    check("async_segcol",  int'(seg_col0),  7'b1000000);
    @(negedge clk);
    rst = 1'b0;

    // Load saturation
    drive(1'b1, 12, 3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("sat_fila",  int'(fila0), 7);
    check("sat_fila1", int'(fila1), 12);

    // Wrap: arriba at row 0, derecha at column 7
    drive(1'b1, 0, 7, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    check("wrap_fila",    int'(fila0),    7);
    check("wrap_columna", int'(columna0), 0);

    // Diagonal from (4,4)
    drive(1'b1, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    check("diag_fila",    int'(fila0),    3);
    check("diag_columna", int'(columna0), 5);

    // Opposing row pulses cancel
    drive(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    check("cancel_fila", int'(fila0), 3);

    // Load wins over a direction pulse
    drive(1'b1, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    check("ldprio_fila",    int'(fila0),    1);
    check("ldprio_columna", int'(columna0), 1);

    // 16x10 board: abajo from 15, izquierda from 0
    drive(1'b1, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    check("big_ld_fila", int'(fila1), 15);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
    check("big_wrap_fila",    int'(fila1),    0);
    check("big_wrap_columna", int'(columna1), 9);
    idle(); tick();
    check("big_segfila", int'(seg_fila1), 7'b1000000);
    check("big_segcol",  int'(seg_col1),  7'b0010000);

    // Blink on the 8x8 board: 4 visible, then blank
    parpadeo_en = 1'b1;
    drive(1'b1, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    idle();
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("blink_%0d", i), int'(seg_fila0),
            (i <= 4) ? 7'b0100100 : 7'b1111111);
    end
    // izquierda during the blank phase restarts a full visible period
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    idle();
    for (int j = 1; j <= 5; j++) begin
      tick();
      check($sformatf("reblink_%0d", j), int'(seg_col0),
            (j <= 4) ? 7'b0011001 : 7'b1111111);
    end

    // Randomised run with sparse activity so blinking is exercised too
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 63) == 0) parpadeo_en = ~parpadeo_en;
      if ($urandom_range(0, 4) == 0) begin
        arriba     = 1'($urandom_range(0, 1));
        abajo      = 1'($urandom_range(0, 1));
        izquierda  = 1'($urandom_range(0, 1));
        derecha    = 1'($urandom_range(0, 1));
        cargar     = ($urandom_range(0, 5) == 0);
        fila_in    = 4'($urandom_range(0, 15));
        columna_in = 4'($urandom_range(0, 15));
      end else begin
        arriba = 1'b0; abajo = 1'b0; izquierda = 1'b0; derecha = 1'b0;
        cargar = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
      end
    end

    @(negedge clk);
    rst = 1'b0;
    idle();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_cursor_display.md
# matrix_cursor_display

Parametrised cursor register and seven-segment driver for the Buscaminas board. It holds the current cursor row/column and moves it on single-cycle direction pulses with wrap-around, and it accepts direct loads. It drives two registered seven-segment digits, blanking both in a blink pattern while selection blinking is enabled. It sits between the button-debounce stage and the board's seven-segment displays, and it replaces the fixed 3-bit combinational position display.

## Interface
- ROWS, 8, number of board rows; 2..16
- COLS, 8, number of board columns; 2..16
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; ≥2
- RW/CW are local: $clog2(ROWS), $clog2(COLS)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- arriba  in  1  single-cycle pulse; row − 1
- abajo  in  1  single-cycle pulse; row + 1
- izquierda  in  1  single-cycle pulse; column − 1
- derecha  in  1  single-cycle pulse; column + 1
- cargar  in  1  load fila_in/columna_in
- fila_in  in  4  row to load
- columna_in  in  4  column to load
- parpadeo_en  in  1  enable blinking
- fila  out  RW  current cursor row (registered)
- columna  out  CW  current cursor column (registered)
- salidaFila  out  7  segments for the row digit; active-low, bit6=g … bit0=a
- salidaColumna  out  7  segments for the column digit; same encoding

## Operation
- Reset (async, rst=1): fila=0, columna=0, blink counter=0, blink phase=0, salidaFila=salidaColumna=7'b1000000 ("0").
- Position update happens on each rising edge, with the following priority:
  - cargar=1: fila ← min(fila_in, ROWS−1) and columna ← min(columna_in, COLS−1). All direction pulses are ignored that cycle.
  - Otherwise, the row and column are handled independently:
    - arriba&abajo both set, or neither set: row holds.
    - arriba only: row ← (fila==0) ? ROWS−1 : fila−1.
    - abajo only: row ← (fila==ROWS−1) ? 0 : fila+1.
    - Column uses izquierda/derecha with the same rules against COLS.
- Diagonal move: a row pulse and a column pulse in the same cycle are both applied.
- Movement event: any cycle where cargar, or any direction pulse that changes a coordinate, is accepted. A movement event clears the blink counter and phase, so the cursor is visible immediately.
- Blink:
  - Counter runs 0..BLINK_DIV−1 continuously.
  - Phase toggles when the counter wraps.
  - When parpadeo_en=1 and phase=1, both outputs are blank (7'b1111111).
  - When parpadeo_en=0, the digits are always shown. The counter keeps running.
- Hex decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- Pulse sampled at edge N: fila/columna hold the new value after edge N. Segment outputs reflect it after edge N+1, so segment latency is 2 edges from pulse assertion.
- Segment outputs are fully registered and glitch-free. Decode uses the registered fila/columna.
- Blank/visible transitions occur one edge after a phase change.
- A pulse held high for k cycles moves the cursor k steps. Debouncing to one cycle is the upstream block's job.
- If rst is asserted mid-blink or mid-move, all state returns to reset values immediately. Normal operation resumes on the first edge after rst deasserts.

## Test plan
- Reset: assert rst while fila=3 → fila=0, columna=0, salidaFila=salidaColumna=1000000 without any clock edge.
- Load: cargar with fila_in=2, columna_in=5 → fila=2, columna=5. Two edges later, salidaFila=0100100 and salidaColumna=0010010.
- Wrap and saturate (ROWS=COLS=8):
  - arriba at fila=0 → 7; derecha at columna=7 → 0.
  - cargar fila_in=12 → fila=7.
- Simultaneous events: arriba+abajo → row unchanged. arriba+derecha from (4,4) → (3,5). cargar+abajo → loaded value only.
- Blink (BLINK_DIV=4, parpadeo_en=1):
  - Outputs alternate 4 cycles digits / 4 cycles 1111111.
  - An izquierda pulse during the blank phase restores visible digits, with a full 4-cycle visible period.
- Non-default size (ROWS=16, COLS=10): abajo from 15 → 0 with salidaFila=1000000. izquierda from 0 → 9 with salidaColumna=0010000.
